// File: rtl/gpu_rect_fill.sv
// Rectangle fill engine: takes one (x, y, w, h, colour) command at a time,
// clips it to the framebuffer and emits one pixel write per accepted cycle
// in raster order. The write port holds while the framebuffer stalls.
module gpu_rect_fill #(
  parameter int FB_W = 320,
  parameter int FB_H = 200,
  parameter int XW   = 9,
  parameter int YW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [XW-1:0] cmd_w,
  input  logic [YW-1:0] cmd_h,
  input  logic          cmd_color,
  output logic          fb_we,
  output logic [XW-1:0] fb_x,
  output logic [YW-1:0] fb_y,
  output logic          fb_color,
  input  logic          fb_stall,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, FILL, FINISH} state_t;

  // Clip bounds carry one extra bit so x+w / y+h never wrap before the min.
  localparam logic [XW:0] FBW_E = (XW+1)'(FB_W);
  localparam logic [YW:0] FBH_E = (YW+1)'(FB_H);

  state_t        state, state_nxt;
  logic [XW-1:0] x0, x0_nxt;
  logic [XW:0]   xe, xe_nxt;
  logic [YW:0]   ye, ye_nxt;
  logic          fb_we_nxt, fb_color_nxt;
  logic [XW-1:0] fb_x_nxt;
  logic [YW-1:0] fb_y_nxt;

  logic [XW:0]   sum_x, x_inc;
  logic [YW:0]   sum_y, y_inc;
  logic          accept, empty;

  assign cmd_ready = (state == IDLE) && rst;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

  assign accept = cmd_valid && cmd_ready;
  assign sum_x  = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign sum_y  = {1'b0, cmd_y} + {1'b0, cmd_h};
  assign x_inc  = {1'b0, fb_x} + (XW+1)'(1);
  assign y_inc  = {1'b0, fb_y} + (YW+1)'(1);
  assign empty  = (cmd_w == '0) || (cmd_h == '0) ||
                  ({1'b0, cmd_x} >= FBW_E) || ({1'b0, cmd_y} >= FBH_E);

  // State and registered write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      x0       <= '0;
      xe       <= '0;
      ye       <= '0;
      fb_we    <= 1'b0;
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= 1'b0;
    end else begin
      state    <= state_nxt;
      x0       <= x0_nxt;
      xe       <= xe_nxt;
      ye       <= ye_nxt;
      fb_we    <= fb_we_nxt;
      fb_x     <= fb_x_nxt;
      fb_y     <= fb_y_nxt;
      fb_color <= fb_color_nxt;
    end
  end

  // Next state: latch/clip on accept, raster-step on each accepted write.
  always_comb begin
    state_nxt    = state;
    x0_nxt       = x0;
    xe_nxt       = xe;
    ye_nxt       = ye;
    fb_we_nxt    = fb_we;
    fb_x_nxt     = fb_x;
    fb_y_nxt     = fb_y;
    fb_color_nxt = fb_color;
    case (state)
      IDLE: begin
        if (accept) begin
          x0_nxt       = cmd_x;
          xe_nxt       = (sum_x < FBW_E) ? sum_x : FBW_E;
          ye_nxt       = (sum_y < FBH_E) ? sum_y : FBH_E;
          fb_color_nxt = cmd_color;
          if (empty) begin
            state_nxt = FINISH;
          end else begin
            state_nxt = FILL;
            fb_we_nxt = 1'b1;
            fb_x_nxt  = cmd_x;
            fb_y_nxt  = cmd_y;
          end
        end
      end
      FILL: begin
        // Stalled writes simply hold everything.
        if (fb_we && !fb_stall) begin
          if (x_inc < xe) begin
            fb_x_nxt = x_inc[XW-1:0];
          end else if (y_inc < ye) begin
            fb_x_nxt = x0;
            fb_y_nxt = y_inc[YW-1:0];
          end else begin
            fb_we_nxt = 1'b0;
            state_nxt = FINISH;
          end
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Directed bench for gpu_rect_fill: handshake timing, clipping, empty
// commands, stall hold, reset abort, back-to-back and full-screen fill.
module tb_gpu_rect_fill;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_color;
  logic [8:0] cmd_x, cmd_w;
  logic [7:0] cmd_y, cmd_h;
  logic       fb_we, fb_color, fb_stall, busy, done;
  logic [8:0] fb_x;
  logic [7:0] fb_y;

  int tests = 0;
  int fails = 0;

  // Captured results of the last command
  int n_wr, n_done, done_k, ready_k, order_err, range_err, hold1;
  int qx[$], qy[$], qk[$];
  int st_lo = 0, st_hi = -1;

  gpu_rect_fill dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
    .fb_color(fb_color), .fb_stall(fb_stall), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Present a command and return just after the edge that accepts it.
  task automatic accept_cmd(input int x, y, w, h, c, output bit ok);
    ok = 0;
    @(negedge clk);
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h);
    cmd_color = c[0]; cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    #1 cmd_valid = 1'b0;
  endtask

  // Run a command; cycle k=1 is the cycle after acceptance. Expected raster
  // window [ex0,ex1) x [ey0,ey1) is hand-supplied by each test.
  task automatic run_cmd(input int x, y, w, h, c, ex0, ex1, ey0, ey1);
    bit ok;
    int cx, cy;
    n_wr = 0; n_done = 0; done_k = -1; ready_k = -1;
    order_err = 0; range_err = 0; hold1 = 0;
    qx.delete(); qy.delete(); qk.delete();
    cx = ex0; cy = ey0;
    accept_cmd(x, y, w, h, c, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL accept: command (%0d,%0d,%0d,%0d) never accepted", x, y, w, h);
      return;
    end
    for (int k = 1; k <= 70000; k++) begin
      @(negedge clk);
      fb_stall = (k >= st_lo && k <= st_hi);
      if (fb_we) begin
        if (fb_x >= 320 || fb_y >= 200) range_err++;
        if (fb_x == 1) hold1++;
        if (!fb_stall) begin
          if (fb_x != cx || fb_y != cy || fb_color != c[0]) order_err++;
          if (qx.size() < 64) begin
            qx.push_back(fb_x); qy.push_back(fb_y); qk.push_back(k);
          end
          n_wr++;
          cx++;
          if (cx >= ex1) begin cx = ex0; cy++; end
        end
      end
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (cmd_ready) begin
        ready_k = k;
        break;
      end
    end
    fb_stall = 1'b0;
    if (ready_k < 0) begin
      fails++;
      $display("FAIL timeout: cmd_ready never returned, writes=%0d", n_wr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({fb_we, busy, done, cmd_ready, fb_color, fb_x, fb_y} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: we=%b busy=%b done=%b ready=%b x=%0d y=%0d expected all 0",
               fb_we, busy, done, cmd_ready, fb_x, fb_y);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%b busy=%b expected 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    run_cmd(10, 5, 2, 2, 1, 10, 12, 5, 7);
    tests++;
    if (n_wr != 4 || order_err != 0) begin
      fails++;
      $display("FAIL basic_writes: got %0d writes %0d order errors, expected 4/0", n_wr, order_err);
    end
    tests++;
    if (qk.size() < 4 || qk[0] != 1 || qk[3] != 4 || qx[1] != 11 || qy[2] != 6) begin
      fails++;
      $display("FAIL basic_timing: first/last write cycles wrong, expected 1 and 4");
    end
    tests++;
    if (done_k != 5 || n_done != 1 || ready_k != 6) begin
      fails++;
      $display("FAIL basic_done: done at %0d (x%0d) ready at %0d, expected 5 (x1) and 6",
               done_k, n_done, ready_k);
    end
  endtask

  task automatic test_clip();
    run_cmd(318, 199, 5, 3, 0, 318, 320, 199, 200);
    tests++;
    if (n_wr != 2 || order_err != 0 || qx.size() < 2 || qx[0] != 318 || qx[1] != 319) begin
      fails++;
      $display("FAIL clip_writes: got %0d writes %0d order errors, expected 2/0", n_wr, order_err);
    end
    tests++;
    if (range_err != 0 || done_k != 3) begin
      fails++;
      $display("FAIL clip_range: %0d out-of-range, done at %0d, expected 0 and 3", range_err, done_k);
    end
  endtask

  task automatic test_empty();
    int ws[3] = '{0, 4, 4};
    int hs[3] = '{4, 0, 4};
    int xs[3] = '{3, 3, 320};
    for (int i = 0; i < 3; i++) begin
      run_cmd(xs[i], 3, ws[i], hs[i], 1, 0, 1, 0, 1);
      tests++;
      if (n_wr != 0 || hold1 != 0 || done_k != 1 || n_done != 1 || ready_k != 2) begin
        fails++;
        $display("FAIL empty_%0d: writes=%0d done at %0d ready at %0d, expected 0/1/2",
                 i, n_wr, done_k, ready_k);
      end
    end
  endtask

  task automatic test_stall();
    st_lo = 2; st_hi = 4;
    run_cmd(0, 0, 4, 1, 1, 0, 4, 0, 1);
    st_lo = 0; st_hi = -1;
    tests++;
    if (n_wr != 4 || order_err != 0) begin
      fails++;
      $display("FAIL stall_seq: got %0d writes %0d order errors, expected 4/0", n_wr, order_err);
    end
    tests++;
    if (hold1 != 4) begin
      fails++;
      $display("FAIL stall_hold: (1,0) presented %0d cycles, expected 4", hold1);
    end
    tests++;
    if (done_k != 8 || ready_k != 9) begin
      fails++;
      $display("FAIL stall_done: done at %0d ready at %0d, expected 8 and 9", done_k, ready_k);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int dn = 0;
    accept_cmd(0, 0, 16, 16, 1, ok);
    repeat (20) @(negedge clk);
    tests++;
    if (!ok || fb_we !== 1'b1) begin
      fails++;
      $display("FAIL abort_prefill: accepted=%0d we=%b expected 1/1", ok, fb_we);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL abort_async: we=%b busy=%b ready=%b expected 0/0/0", fb_we, busy, cmd_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if (done) dn++;
    tests++;
    if (cmd_ready !== 1'b1 || dn != 0) begin
      fails++;
      $display("FAIL abort_release: ready=%b done pulses=%0d expected 1/0", cmd_ready, dn);
    end
    run_cmd(5, 5, 1, 1, 1, 5, 6, 5, 6);
    tests++;
    if (n_wr != 1 || order_err != 0 || hold1 != 0 || done_k != 2) begin
      fails++;
      $display("FAIL abort_refill: writes=%0d order errors=%0d done at %0d expected 1/0/2",
               n_wr, order_err, done_k);
    end
  endtask

  task automatic test_back_to_back();
    bit acc = 0;
    @(negedge clk);
    cmd_x = 9'd2; cmd_y = 8'd2; cmd_w = 9'd2; cmd_h = 8'd1; cmd_color = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      if (cmd_ready) acc = 1;
      @(negedge clk);
    end
    // Now at negedge of cycle k=1 after acceptance of cmd1
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) begin
        tests++;
        if (fb_we !== 1'b1 || fb_x !== 9'd2 || fb_y !== 8'd2) begin
          fails++;
          $display("FAIL b2b_first: we=%b x=%0d y=%0d expected 1,2,2", fb_we, fb_x, fb_y);
        end
      end
      if (k == 3) begin
        tests++;
        if (done !== 1'b1 || cmd_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_done1: done=%b ready=%b expected 1/0", done, cmd_ready);
        end
        cmd_x = 9'd7; cmd_y = 8'd8; cmd_w = 9'd1; cmd_h = 8'd1; cmd_color = 1'b0;
      end
      if (k == 4) begin
        tests++;
        if (cmd_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_ready: ready=%b expected 1 in cycle after done", cmd_ready);
        end
      end
      if (k == 5) begin
        tests++;
        if (fb_we !== 1'b1 || fb_x !== 9'd7 || fb_y !== 8'd8 || fb_color !== 1'b0) begin
          fails++;
          $display("FAIL b2b_second: we=%b x=%0d y=%0d c=%b expected 1,7,8,0",
                   fb_we, fb_x, fb_y, fb_color);
        end
        cmd_valid = 1'b0;
      end
      if (k == 6) begin
        tests++;
        if (done !== 1'b1) begin
          fails++;
          $display("FAIL b2b_done2: done=%b expected 1", done);
        end
      end
    end
    @(negedge clk);
    run_cmd(0, 0, 320, 200, 1, 0, 320, 0, 200);
    tests++;
    if (n_wr != 64000 || order_err != 0 || range_err != 0) begin
      fails++;
      $display("FAIL fullscreen: writes=%0d order errors=%0d range errors=%0d expected 64000/0/0",
               n_wr, order_err, range_err);
    end
    tests++;
    if (done_k != 64001 || ready_k != 64002) begin
      fails++;
      $display("FAIL fullscreen_done: done at %0d ready at %0d expected 64001/64002", done_k, ready_k);
    end
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; fb_stall = 1'b0; cmd_color = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpu_rect_fill.md
Name: gpu_rect_fill

Overview:
- Rectangle fill engine upstream of the VGA scan-out stage.
- Accepts fill commands (x, y, w, h, colour) over a valid/ready handshake.
- Writes the clipped rectangle into the 320x200 1-bit framebuffer, one pixel per cycle, in raster order.
- Framebuffer write port honours a stall input; the command side reports busy/done.

Parameters:
- FB_W, 320, framebuffer width in pixels.
- FB_H, 200, framebuffer height in lines.
- XW, 9, x coordinate / width bus width.
- YW, 8, y coordinate / height bus width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x  in  XW  left column.
- cmd_y  in  YW  top line.
- cmd_w  in  XW  width in pixels.
- cmd_h  in  YW  height in lines.
- cmd_color  in  1  pixel value to write.
- fb_we  out  1  framebuffer pixel write strobe.
- fb_x  out  XW  write column.
- fb_y  out  YW  write line.
- fb_color  out  1  write data.
- fb_stall  in  1  framebuffer cannot take the write this cycle.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - fb_we, fb_x, fb_y, fb_color, busy and done all go to 0.
  - No command is accepted while rst=0.
- States: IDLE, FILL, FINISH.
- cmd_ready = 1 only in IDLE with rst=1. busy = 1 in FILL and FINISH.
- Acceptance happens on a cycle N with cmd_valid & cmd_ready. The engine latches x0=cmd_x, y0=cmd_y and colour, and computes clip ends with one extra bit of width:
  - xe = min(cmd_x+cmd_w, FB_W)
  - ye = min(cmd_y+cmd_h, FB_H)
- Empty command: if cmd_w==0, cmd_h==0, cmd_x>=FB_W or cmd_y>=FB_H:
  - IDLE goes to FINISH with no writes.
  - done=1 in cycle N+1.
- Otherwise IDLE goes to FILL:
  - fb_we=1 with fb_x=x0, fb_y=y0 in cycle N+1. All fb_* outputs are registered.
- Write acceptance: a write is accepted in any cycle with fb_we & !fb_stall. The engine then advances:
  - If fb_x+1 < xe: fb_x+1.
  - Else if fb_y+1 < ye: fb_x=x0, fb_y+1.
  - Else (last pixel): fb_we goes to 0 and the state goes to FINISH.
- Stall: while fb_we & fb_stall, all fb_* outputs hold their values. No pixel is skipped or duplicated.
- FINISH:
  - Lasts exactly one cycle with done=1, then returns to IDLE.
  - cmd_ready is 1 in the following cycle.
- Throughput: a clipped area of P pixels with no stalls gives writes in cycles N+1..N+P, done in N+P+1 and cmd_ready in N+P+2.
- No wrap-around: coordinates never exceed FB_W-1 / FB_H-1. Overflow of x+w or y+h is absorbed by the extra bit before the min.
- cmd_* inputs are ignored outside IDLE. Changing them mid-fill has no effect.
- fb_stall is ignored when fb_we=0.
- Reset mid-fill aborts immediately: fb_we=0, no done pulse, IDLE. cmd_ready=1 on the first cycle after rst returns to 1.
- Overlapping commands are processed strictly sequentially. The last write wins.

Test Plan:
- Reset, then cmd (x=10,y=5,w=2,h=2,color=1) accepted at cycle N -> writes (10,5),(11,5),(10,6),(11,6) in N+1..N+4, done=1 at N+5 only, cmd_ready=1 at N+6.
- Clipping: (x=318,y=199,w=5,h=3,color=0) -> exactly two writes, (318,199) then (319,199), then done. Check that no x>=320 or y>=200 ever appears.
- Empty commands: w=0, then h=0, then x=320 -> each gives no fb_we, done exactly one cycle after acceptance.
- Stall: 4x1 fill at (0,0), fb_stall=1 for 3 cycles while (1,0) is presented -> (1,0) held for 4 cycles total, sequence 0,1,2,3 with no gaps or repeats, done 3 cycles later than the unstalled case.
- Reset abort: assert rst=0 mid-way through a 16x16 fill -> fb_we=0 and busy=0 asynchronously. After release, cmd_ready=1, no done pulse, and a new 1x1 fill at (5,5) writes only (5,5).
- Back-to-back: cmd_valid held high with two commands -> the second is accepted in the cycle after done. Full-screen fill (0,0,320,200) produces exactly 64000 writes in raster order.
